keypad_debounce: RTL and testbench

//  Front-end for the nap machine's 10-key keypad and '#' key. Sits directly upstream of

---
 rtl/keypad_debounce.sv | 150 +++++++++++++++
 tb/tb_keypad_debounce.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/keypad_debounce.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | keypad_debounce: sync + shared-counter debounce of 10 digits and '#', with  |
// | chord-rejecting press FSM and one-cycle press strobes.                      |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module keypad_debounce #(
  parameter int DEBOUNCE_CNT = 10000,
  parameter int CNT_W        = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] raw_keypad,
  input  logic       raw_sharp,
  output logic [9:0] keypad,
  output logic       sharp,
  output logic       key_pulse,
  output logic [3:0] key_code,
  output logic       sharp_pulse,
  output logic       multi_key
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_MULTI = 2'd2
  } key_state_e;

  // Bit 10 carries '#', bits 9:0 the digits; the whole word debounces as one.
  logic [10:0]      sync1_q, sync1_d;
  logic [10:0]      sync2_q, sync2_d;
  logic [10:0]      cand_q, cand_d;
  logic [10:0]      stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  key_state_e       state_q, state_d;
  logic             key_pulse_q, key_pulse_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             multi_key_q, multi_key_d;
  logic             sharp_d1_q, sharp_d1_d;
  logic             sharp_pulse_q, sharp_pulse_d;

  logic [9:0]       w_k;
  logic [3:0]       w_key_cnt;
  logic [3:0]       w_key_idx;
  logic             w_one_hot;
  logic             w_many;

  always_comb begin
    sync1_d  = {raw_sharp, raw_keypad};
    sync2_d  = sync1_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == C_CNT_LAST) begin
      stable_d = cand_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    w_k       = stable_q[9:0];
    w_key_cnt = 4'd0;
    w_key_idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (w_k[i]) begin
        w_key_cnt = w_key_cnt + 4'd1;
        w_key_idx = 4'(i);
      end
    end
    w_one_hot = (w_key_cnt == 4'd1);
    w_many    = (w_key_cnt > 4'd1);
  end

  always_comb begin
    state_d     = state_q;
    key_pulse_d = 1'b0;
    key_code_d  = key_code_q;
    case (state_q)
      ST_IDLE: begin
        if (w_one_hot) begin
          state_d     = ST_PRESS;
          key_pulse_d = 1'b1;
          key_code_d  = w_key_idx;
        end else if (w_many) begin
          state_d = ST_MULTI;
        end
      end
      ST_PRESS: begin
        // Any change away from the accepted digit is treated as a chord.
        if (w_k == 10'd0) begin
          state_d = ST_IDLE;
        end else if (w_k != (10'd1 << key_code_q)) begin
          state_d = ST_MULTI;
        end
      end
      ST_MULTI: begin
        if (w_k == 10'd0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    multi_key_d   = w_many;
    sharp_d1_d    = stable_q[10];
    sharp_pulse_d = stable_q[10] & ~sharp_d1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      cand_q        <= '0;
      stable_q      <= '0;
      cnt_q         <= '0;
      state_q       <= ST_IDLE;
      key_pulse_q   <= 1'b0;
      key_code_q    <= 4'd0;
      multi_key_q   <= 1'b0;
      sharp_d1_q    <= 1'b0;
      sharp_pulse_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      cand_q        <= cand_d;
      stable_q      <= stable_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      key_pulse_q   <= key_pulse_d;
      key_code_q    <= key_code_d;
      multi_key_q   <= multi_key_d;
      sharp_d1_q    <= sharp_d1_d;
      sharp_pulse_q <= sharp_pulse_d;
    end
  end

  assign keypad      = stable_q[9:0];
  assign sharp       = stable_q[10];
  assign key_pulse   = key_pulse_q;
  assign key_code    = key_code_q;
  assign sharp_pulse = sharp_pulse_q;
  assign multi_key   = multi_key_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_debounce.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_keypad_debounce: directed + random stimulus against a reference model.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_keypad_debounce;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] raw_keypad = '0;
  logic       raw_sharp = 1'b0;
  logic [9:0] keypad;
  logic       sharp;
  logic       key_pulse;
  logic [3:0] key_code;
  logic       sharp_pulse;
  logic       multi_key;

  always #5 clk = ~clk;

  keypad_debounce #(.DEBOUNCE_CNT(DC), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .raw_keypad(raw_keypad), .raw_sharp(raw_sharp),
    .keypad(keypad), .sharp(sharp), .key_pulse(key_pulse), .key_code(key_code),
    .sharp_pulse(sharp_pulse), .multi_key(multi_key)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: a level is accepted once DC+1 consecutive synchronised samples
  // agree; samples reach the debouncer two edges after being taken.
  logic [10:0] hist[$];
  logic [10:0] stable_m = '0;
  logic [10:0] prev_m = '0;
  logic        exp_kp = 1'b0;
  logic        exp_sp = 1'b0;
  logic        exp_mk = 1'b0;
  logic [3:0]  exp_code = 4'd0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [10:0] raw);
    bit all_eq;
    int nbits;
    if (r) begin
      hist.delete();
      for (int i = 0; i < DC + 3; i++) hist.push_back(11'd0);
      stable_m = '0;
      prev_m   = '0;
      exp_kp   = 1'b0;
      exp_sp   = 1'b0;
      exp_mk   = 1'b0;
      exp_code = 4'd0;
    end else begin
      nbits  = $countones(stable_m[9:0]);
      // A press is the first nonzero digit set after all-released, if single.
      exp_kp = (nbits == 1) && (prev_m[9:0] == 10'd0);
      if (exp_kp) begin
        for (int i = 0; i < 10; i++) if (stable_m[i]) exp_code = 4'(i);
      end
      exp_mk = (nbits > 1);
      exp_sp = stable_m[10] & ~prev_m[10];
      prev_m = stable_m;
      hist.push_back(raw);
      void'(hist.pop_front());
      all_eq = 1'b1;
      for (int i = 1; i <= DC; i++) if (hist[i] != hist[0]) all_eq = 1'b0;
      if (all_eq) stable_m = hist[DC];
    end
  endtask

  task automatic step(input logic [9:0] kp, input logic sh, input logic r);
    raw_keypad = kp;
    raw_sharp  = sh;
    rst        = r;
    @(posedge clk);
    model_edge(r, {sh, kp});
    #1;
    check("keypad", 32'(keypad), 32'(stable_m[9:0]));
    check("sharp", 32'(sharp), 32'(stable_m[10]));
    check("key_pulse", 32'(key_pulse), 32'(exp_kp));
    check("key_code", 32'(key_code), 32'(exp_code));
    check("multi_key", 32'(multi_key), 32'(exp_mk));
    check("sharp_pulse", 32'(sharp_pulse), 32'(exp_sp));
  endtask

  task automatic hold(input logic [9:0] kp, input logic sh, input int n);
    for (int i = 0; i < n; i++) step(kp, sh, 1'b0);
  endtask

  initial begin
    logic [9:0] cur;
    logic       sh;
    int         len;
    cur = '0;

    // Reset with every digit held, then release reset.
    step(10'h3FF, 1'b0, 1'b1);
    step(10'h3FF, 1'b0, 1'b1);
    hold(10'h3FF, 1'b0, 12);
    hold(10'h000, 1'b0, 10);

    // Clean press of digit 5.
    hold(10'h020, 1'b0, 20);
    hold(10'h000, 1'b0, 12);

    // Bouncing digit 3.
    for (int i = 0; i < 10; i++) step(((i % 4) < 2) ? 10'h008 : 10'h000, 1'b0, 1'b0);
    hold(10'h008, 1'b0, 12);
    hold(10'h000, 1'b0, 12);

    // Chord 2 + 7, partial release, then a fresh 7.
    hold(10'h004, 1'b0, 10);
    hold(10'h084, 1'b0, 10);
    hold(10'h004, 1'b0, 10);
    hold(10'h000, 1'b0, 10);
    hold(10'h080, 1'b0, 10);
    hold(10'h000, 1'b0, 10);

    // Sharp with digit 1 together, then a short sharp glitch.
    hold(10'h002, 1'b1, 10);
    hold(10'h000, 1'b0, 10);
    hold(10'h000, 1'b1, 3);
    hold(10'h000, 1'b0, 10);

    // Reset in the middle of debouncing digit 9.
    hold(10'h200, 1'b0, 3);
    step(10'h200, 1'b0, 1'b1);
    hold(10'h200, 1'b0, 12);
    hold(10'h000, 1'b0, 10);

    // Random phases of held levels with occasional resets.
    for (int p = 0; p < 400; p++) begin
      case ($urandom_range(0, 3))
        0: cur = 10'd0;
        1: cur = 10'd1 << $urandom_range(0, 9);
        2: cur = 10'($urandom);
        default: cur = cur ^ (10'd1 << $urandom_range(0, 9));
      endcase
      sh  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 10);
      if ($urandom_range(0, 49) == 0) begin
        for (int i = 0; i < $urandom_range(1, 2); i++) step(cur, sh, 1'b1);
      end
      hold(cur, sh, len);
    end
    hold(10'h000, 1'b0, 12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
